sine_rom_lut: RTL and testbench
===============================

// Module: sine_rom_lut
// PURPOSE
//  Synchronous 4096-point, 8-bit signed sine look-up ROM used by the DDS/AM generators.
//  A phase-accumulator MSB slice drives the address; the registered output is one full
//  sine period over the address range. Callers add 8'd128 for offset-binary DAC codes.
//  Storage is a 1025-entry quarter-wave table plus quadrant symmetry logic.
// PARAMETERS
//  ADDR_W    12                  phase address width; only the default is supported
//  DATA_W    8                   output width, two's complement
//  QTR_FILE  "sine_quarter.mem"  $readmemh image of the quarter-wave table, 1025 lines
// PORTS
//  clk    in   1       system clock; all state updates on its rising edge
//  rst_n  in   1       asynchronous active-low reset
//  a      in   12      phase address: 0..4095 maps to 0..2*pi*(4095/4096)
//  spo    out  8       signed sine sample, registered
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Function: spo = round(127*sin(2*pi*a/4096)). Rounding is half away from zero.
//    Range is -127..+127; -128 never appears.
//  - Quarter table Q[k] = round(127*sin(2*pi*k/4096)) for k = 0..1024.
//    Q[0] = 0 and Q[1024] = 127.
//  - Quadrant select is a[11:10]; low = a[9:0].
//    00 -> +Q[low]; 01 -> +Q[1024-low]
//    10 -> -Q[low]; 11 -> -Q[1024-low]
//    A 01 or 11 quadrant with low = 0 indexes Q[1024]. Negation of 0 gives 0.
//  - Latency: 1 cycle. The value for `a` sampled at rising edge N is on spo after edge N.
//    The address is not held; a new address is accepted every cycle.
//  - rst_n low: spo is forced to 8'h00 immediately, without waiting for clk, and holds
//    while rst_n is low.
//  - First rising edge after rst_n deasserts: registers the value for the current `a`.
//  - Reset mid-stream: the output drops to 0 asynchronously. The ROM has no other state,
//    so no recovery sequence is needed.
//  - Address wrap: 4095 -> 0 is continuous. 4095 gives round(127*sin(-2*pi/4096)) = 0.
//  - Contents are constant. There is no write port and no enable; spo updates every cycle
//    when out of reset.
//  - Synthesis: the table infers as distributed or block ROM. The only sequential element
//    is the DATA_W-bit output register with async clear.
// TESTING
//  1. Reset: hold rst_n = 0 with a = 1024 and clk toggling -> spo stays 8'h00.
//     Deassert -> spo = 8'sd127 one edge later.
//  2. Cardinal points, applied back to back one per cycle:
//     a = 0, 1024, 2048, 3072 -> spo = 0, 127, 0, -127 (8'h81), each one cycle late.
//  3. Octants: a = 512 -> 90; a = 1536 -> 90; a = 2560 -> -90; a = 3584 -> -90.
//     a = 10 -> 2; a = 1 -> 0.
//  4. Sweep a = 0..4095 with a counter stepping by 1, and by 64 as in the AM modulator.
//     Every spo must equal the reference-model formula, delayed 1 cycle.
//     spo must satisfy odd symmetry: spo(a) = -spo(4096-a).
//  5. Async reset mid-sweep: pulse rst_n low between clock edges -> spo = 0 within the
//     same delta, without a clock edge. After release the sweep resumes matching the model.
//  6. Wrap: drive a = 4094, 4095, 0, 1 -> spo = 0, 0, 0, 0. No glitch at the wrap.

Source files
------------

// File: rtl/sine_rom_lut.sv
// Synchronous full-period sine ROM: a 1025-entry quarter-wave table folded by quadrant,
// with one registered output stage cleared asynchronously.
module sine_rom_lut #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 8,
    parameter string       QTR_FILE = "sine_quarter.mem"
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        a,
    output logic signed [DATA_W-1:0] spo
);

    localparam int unsigned LOW_W   = ADDR_W - 2;
    localparam int unsigned IDX_W   = ADDR_W - 1;
    localparam int unsigned MAG_W   = DATA_W - 1;
    localparam int unsigned QTR_N   = 1 << LOW_W;
    localparam int unsigned AMP     = (1 << MAG_W) - 1;
    localparam int unsigned FRAC    = 48;
    localparam int unsigned TAYLOR_N = 11;
    localparam logic [127:0] ONE    = 128'(1) << FRAC;
    localparam logic [127:0] HALF   = 128'(1) << (FRAC - 1);
    // pi scaled by 2^48
    localparam logic [127:0] PI_F   = 128'd884279719003555;

    // Elaboration-time entry k: round(AMP*sin(pi*k/(2*QTR_N))) in 48-bit fixed point,
    // sine via a Horner-form Taylor series; every intermediate stays non-negative.
    function automatic logic [MAG_W-1:0] qtr_entry(input int unsigned k);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] h;
        logic [127:0] s;
        logic [127:0] y;
        x  = (128'(k) * PI_F) / 128'(2 * QTR_N);
        x2 = (x * x) >> FRAC;
        h  = ONE;
        for (int n = TAYLOR_N; n > 0; n--) begin
            h = ONE - (((x2 * h) >> FRAC) / 128'(2 * n * (2 * n + 1)));
        end
        s = (x * h) >> FRAC;
        y = (s * 128'(AMP) + HALF) >> FRAC;
        return MAG_W'(y);
    endfunction

    // Contents are computed here; QTR_FILE only names the equivalent image for ROM-macro flows.
    if (QTR_FILE == "") begin : g_no_image_name
    end

    logic [MAG_W-1:0] qtr [0:QTR_N];

    for (genvar k = 0; k <= QTR_N; k++) begin : g_qtr
        localparam logic [MAG_W-1:0] QV = qtr_entry(k);
        assign qtr[k] = QV;
    end

    logic [1:0]              quad_c;
    logic [LOW_W-1:0]        low_c;
    logic [IDX_W-1:0]        idx_c;
    logic [MAG_W-1:0]        mag_c;
    logic signed [DATA_W-1:0] samp_c;

    // Quadrant fold: odd quadrants mirror the index, upper half negates the magnitude.
    always_comb begin
        quad_c = a[ADDR_W-1:ADDR_W-2];
        low_c  = a[LOW_W-1:0];
        idx_c  = IDX_W'(low_c);
        if (quad_c[0]) begin
            idx_c = IDX_W'(QTR_N) - IDX_W'(low_c);
        end
        mag_c  = qtr[idx_c];
        samp_c = {1'b0, mag_c};
        if (quad_c[1]) begin
            samp_c = DATA_W'(0) - {1'b0, mag_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spo <= '0;
        end else begin
            spo <= samp_c;
        end
    end

endmodule

// File: tb/tb_sine_rom_lut.sv
// Directed bench for sine_rom_lut: hand-computed vector table, full sweeps against a
// real-valued sine model, odd symmetry, async reset and address wrap.
module tb_sine_rom_lut;

    localparam real PI = 3.14159265358979323846;

    typedef struct {
        logic [11:0]        a;
        logic signed [7:0]  exp;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [11:0]       a;
    logic signed [7:0] spo;

    int checks;
    int errors;
    int got [0:4095];
    vec_t vecs [$];

    sine_rom_lut dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .spo   (spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model(input int addr);
        real y;
        y = 127.0 * $sin(2.0 * PI * real'(addr) / 4096.0);
        if (y >= 0.0) return int'($floor(y + 0.5));
        return -int'($floor(-y + 0.5));
    endfunction

    task automatic check(input string name, input logic signed [7:0] act,
                         input logic signed [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: spo=%0d expected %0d", name, act, req);
        end
    endtask

    task automatic add(input int addr, input int val);
        vec_t v;
        v.a   = 12'(addr);
        v.exp = 8'(val);
        vecs.push_back(v);
    endtask

    // Drive one address per cycle; each result is checked one cycle after it was driven.
    task automatic sweep(input int step, input int count, input string tag);
        int prev;
        prev = 0;
        for (int i = 0; i <= count; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("%s a=%0d", tag, prev), spo, 8'(model(prev)));
                if (step == 1) got[prev] = int'(spo);
            end
            if (i < count) begin
                prev = (i * step) % 4096;
                a    = 12'(prev);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        a      = 12'd1024;

        // cardinals, octants, small angles, near-peak, wrap (hand-computed)
        add(0, 0);     add(1024, 127); add(2048, 0);   add(3072, -127);
        add(512, 90);  add(1536, 90);  add(2560, -90); add(3584, -90);
        add(10, 2);    add(1, 0);      add(256, 49);   add(768, 117);
        add(2304, -49); add(3840, -49); add(1023, 127); add(1025, 127);
        add(3071, -127); add(3073, -127); add(5, 1);   add(3, 1);
        add(2, 0);     add(4093, -1);
        add(4094, 0);  add(4095, 0);   add(0, 0);      add(1, 0);

        // reset held with clock running
        #2 rst_n = 1'b0;
        #1 check("reset_async_clear", spo, 8'sd0);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", spo, 8'sd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release a=1024", spo, 8'sd127);

        // back-to-back table
        for (int i = 0; i <= vecs.size(); i++) begin
            @(negedge clk);
            if (i > 0) check($sformatf("vec[%0d] a=%0d", i - 1, vecs[i-1].a), spo, vecs[i-1].exp);
            if (i < vecs.size()) a = vecs[i].a;
        end

        sweep(1, 4096, "sweep1");
        sweep(64, 64, "sweep64");

        for (int k = 1; k < 4096; k++) begin
            check($sformatf("odd_sym a=%0d", k), 8'(got[k]), 8'(-got[4096 - k]));
        end

        // async reset between clock edges, then resume
        @(negedge clk);
        a = 12'd256;
        @(negedge clk);
        check("pre_reset a=256", spo, 8'sd49);
        a = 12'd768;
        @(posedge clk);
        #2 check("pre_reset a=768", spo, 8'sd117);
        rst_n = 1'b0;
        #1 check("mid_reset_async_clear", spo, 8'sd0);
        @(negedge clk);
        check("mid_reset_hold", spo, 8'sd0);
        rst_n = 1'b1;
        a     = 12'd3584;
        @(negedge clk);
        check("resume a=3584", spo, -8'sd90);
        a = 12'd1000;
        @(negedge clk);
        check("resume a=1000", spo, 8'(model(1000)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
